// File: rtl/factorial_inverse.sv
// factorial_inverse: sequential inverse factorial.
// Given a WIDTH-bit value, searches for n with n! == value. The search keeps a
// running product 1,1,2,6,24,... and does one compare and one multiply per clock.
//
// Parameters:
//   WIDTH  width of value
//   NW     width of n; must hold (largest n with n! < 2^WIDTH) + 1
// Optional build macro:
//   INVFACT_FLOOR_EN  when defined, a non-exact result reports the floor index
//                     (largest m with m! <= value); otherwise it reports n=0.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request; sampled only while busy is low
//   value  operand; latched on the accepted start edge
//   busy   high from the cycle after an accepted start through the done cycle
//   done   one-cycle completion pulse
//   n      result index; valid with done and held until the next result
//   exact  1 when value is exactly n!
module factorial_inverse #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [NW-1:0]    n,
    output logic             exact
);

    // Product width leaves NW bits of headroom, so the final overshoot cannot wrap.
    localparam int unsigned PW = WIDTH + NW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] val, val_nxt;
    logic [NW-1:0]    k, k_nxt;
    logic [PW-1:0]    prod, prod_nxt;
    logic [NW-1:0]    res_n, res_n_nxt;
    logic             res_exact, res_exact_nxt;
    logic             busy_nxt, done_nxt;
    logic [NW-1:0]    n_nxt;
    logic             exact_nxt;
    logic [NW-1:0]    k_inc;

    assign k_inc = k + NW'(1);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            val       <= '0;
            k         <= '0;
            prod      <= PW'(1);
            res_n     <= '0;
            res_exact <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            n         <= '0;
            exact     <= 1'b0;
        end else begin
            state     <= state_nxt;
            val       <= val_nxt;
            k         <= k_nxt;
            prod      <= prod_nxt;
            res_n     <= res_n_nxt;
            res_exact <= res_exact_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            n         <= n_nxt;
            exact     <= exact_nxt;
        end
    end

    // Next-state and output logic. busy/done trail the state by one register,
    // so the done pulse lands in the cycle after DONE and start is refused
    // until busy has dropped.
    always_comb begin
        state_nxt     = state;
        val_nxt       = val;
        k_nxt         = k;
        prod_nxt      = prod;
        res_n_nxt     = res_n;
        res_exact_nxt = res_exact;
        n_nxt         = n;
        exact_nxt     = exact;
        done_nxt      = 1'b0;
        busy_nxt      = (state != IDLE);

        case (state)
            IDLE: begin
                if (start && !busy) begin
                    val_nxt   = value;
                    k_nxt     = '0;
                    prod_nxt  = PW'(1);
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (prod == PW'(val)) begin
                    res_n_nxt     = k;
                    res_exact_nxt = 1'b1;
                    state_nxt     = DONE;
                end else if (prod > PW'(val)) begin
                    res_exact_nxt = 1'b0;
`ifdef INVFACT_FLOOR_EN
                    // k has just overshot; the floor is k-1, and value==0 stays at 0.
                    res_n_nxt     = (k == '0) ? '0 : k - NW'(1);
`else
                    res_n_nxt     = '0;
`endif
                    state_nxt     = DONE;
                end else begin
                    k_nxt    = k_inc;
                    prod_nxt = prod * PW'(k_inc);
                end
            end
            DONE: begin
                n_nxt     = res_n;
                exact_nxt = res_exact;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_factorial_inverse.sv
// Testbench for factorial_inverse: directed cases plus a few random operands,
// results checked against a scoreboard of expected n/exact/latency.
module tb_factorial_inverse;

`ifdef INVFACT_FLOOR_EN
    localparam bit FLOOR = 1'b1;
`else
    localparam bit FLOOR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] value = '0;
    logic        busy;
    logic        done;
    logic [3:0]  n;
    logic        exact;

    factorial_inverse #(.WIDTH(16), .NW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .n     (n),
        .exact (exact)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int exact;
        int lat;
        int start_edge;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    int   busy_cnt = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: smallest k with k! >= v decides everything.
    function automatic void model(input int v, output int en, output int eex, output int elat);
        longint f = 1;
        int     k = 0;
        while (f < longint'(v)) begin
            k++;
            f = f * k;
        end
        eex  = (f == longint'(v)) ? 1 : 0;
        en   = (eex == 1) ? k : ((FLOOR && k > 0) ? k - 1 : 0);
        elat = k + 2;
    endfunction

    // Output monitor: pops the scoreboard on every done.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (rst) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (done_prev) chk("busy_after_done", int'(busy), 0);
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e   = q.pop_front();
                    lat = edge_cnt - e.start_edge - 1;
                    chk("n", int'(n), e.n);
                    chk("exact", int'(exact), e.exact);
                    chk("latency", lat, e.lat);
                    chk("busy_cycles", busy_cnt, e.lat);
                end
                busy_cnt = 0;
            end
            done_prev = done;
        end
    end

    task automatic launch(input int v, input int en, input int eex, input int elat);
        exp_t e;
        @(negedge clk);
        value = 16'(v);
        start = 1'b1;
        e.n = en;
        e.exact = eex;
        e.lat = elat;
        e.start_edge = edge_cnt;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        value = 16'($urandom);
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((q.size() != 0 || busy) && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk("op_completes", int'(q.size() == 0 && !busy), 1);
        q.delete();
    endtask

    task automatic run_model(input int v);
        int en, eex, elat;
        model(v, en, eex, elat);
        launch(v, en, eex, elat);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_n", int'(n), 0);
        chk("rst_exact", int'(exact), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // Reset pulse while idle.
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);

        // value == 1 reports canonical 0!.
        launch(1, 0, 1, 2);
        wait_idle();
        // Exact factorials.
        launch(120, 5, 1, 7);
        wait_idle();
        launch(40320, 8, 1, 10);
        wait_idle();
        // Non-exact, including the worst-case latency.
        launch(100, FLOOR ? 4 : 0, 0, 7);
        wait_idle();
        launch(65535, FLOOR ? 8 : 0, 0, 11);
        wait_idle();
        // value == 0.
        launch(0, 0, 0, 2);
        wait_idle();

        // Starts while busy are ignored.
        launch(720, 6, 1, 8);
        @(negedge clk);
        value = 16'd24;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen_720", int'(done), 1);
        value = 16'd24;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (15) @(negedge clk);

        // Reset in the middle of a calculation.
        @(negedge clk);
        value = 16'd5040;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_n", int'(n), 0);
        chk("abort_exact", int'(exact), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        launch(6, 3, 1, 5);
        wait_idle();

        // Random operands and every representable factorial.
        for (int i = 0; i < 6; i++) run_model(int'($urandom_range(0, 65535)));
        begin
            int f = 1;
            for (int i = 1; i <= 8; i++) begin
                f = f * i;
                run_model(f);
                run_model(f + 1);
            end
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
